audio_frame_buffer: RTL and testbench

- Upstream neighbour of the 32-point FFT processor.
- Accepts a stream of signed 18-bit audio samples into a 32-deep sliding window. When enough fresh samples have arrived and the FFT reports done, it snapshots the window into a stable frame register and pulses new_t.
- Tracks the FFT busy/done cycle so each frame is issued exactly once, and flags samples lost to FFT back-pressure.

---
 rtl/audio_frame_buffer_if.sv | 24 ++
 rtl/audio_frame_buffer.sv | 108 ++++++++++
 tb/tb_audio_frame_buffer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/audio_frame_buffer_if.sv
// Sample stream in, frame handshake out: the bundle between the audio
// front end, the frame buffer and the 32-point FFT.
interface audio_frame_buffer_if #(
  parameter int N        = 32,
  parameter int SAMPLE_W = 18
);
  logic signed [SAMPLE_W-1:0] sample_in;
  logic                       sample_valid;
  logic                       fft_done;
  logic [N*SAMPLE_W-1:0]      x_flat;
  logic                       new_t;
  logic                       overrun;
  logic [15:0]                frame_cnt;

  modport master (
    output sample_in, sample_valid, fft_done,
    input  x_flat, new_t, overrun, frame_cnt
  );

  modport slave (
    input  sample_in, sample_valid, fft_done,
    output x_flat, new_t, overrun, frame_cnt
  );
endinterface

// File: rtl/audio_frame_buffer.sv
// Sliding 32-sample window feeding the FFT. Once HOP fresh samples have
// arrived and the FFT is idle, the window is frozen into x_flat and new_t
// strobes. The busy/done cycle of the FFT is tracked so every frame is
// issued exactly once; samples dropped by FFT back-pressure raise overrun.
module audio_frame_buffer #(
  parameter int N            = 32,
  parameter int SAMPLE_W     = 18,
  parameter int HOP          = 16,
  parameter int BUSY_TIMEOUT = 8
) (
  input logic                clk,
  input logic                rst,
  audio_frame_buffer_if.slave bus
);
  localparam int CNT_W = $clog2(N + 1);
  localparam int BT_W  = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {PRIME, ARMED, ISSUE, WAIT_BUSY} state_t;

  state_t                     state;
  logic signed [SAMPLE_W-1:0] win_p0  [N];
  logic signed [SAMPLE_W-1:0] win_nxt [N];
  logic [N*SAMPLE_W-1:0]      flat_nxt;
  logic [CNT_W-1:0]           fill;
  logic [CNT_W-1:0]           fresh;
  logic [BT_W-1:0]            busy_cnt;
  logic                       issue_go;

  // Counter that stops at the window length instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                input logic en);
    return (en && (c != CNT_W'(N))) ? c + 1'b1 : c;
  endfunction

  // Next window: shift toward index 0, newest sample enters at the top.
  always_comb begin
    win_nxt = win_p0;
    if (bus.sample_valid) begin
      for (int k = 0; k < N - 1; k++) win_nxt[k] = win_p0[k+1];
      win_nxt[N-1] = bus.sample_in;
    end
    flat_nxt = '0;
    for (int k = 0; k < N; k++) flat_nxt[SAMPLE_W*k +: SAMPLE_W] = win_nxt[k];
  end

  assign issue_go = (state == ARMED) && bus.fft_done && (fresh >= CNT_W'(HOP));

  // Window capture stage: always holds the latest N samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) win_p0[k] <= '0;
    end else begin
      win_p0 <= win_nxt;
    end
  end

  // Frame control FSM. The issue decision is taken in ARMED and registered,
  // so the frame (including any sample on that edge) appears in x_flat in
  // the same cycle new_t is high, i.e. the ISSUE cycle. A sample arriving
  // during ISSUE is therefore outside the frame and counts as fresh=1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= PRIME;
      fill       <= '0;
      fresh      <= '0;
      busy_cnt   <= '0;
      bus.x_flat <= '0;
      bus.new_t  <= 1'b0;
      bus.overrun <= 1'b0;
      bus.frame_cnt <= '0;
    end else begin
      bus.new_t <= 1'b0;
      fill      <= sat_inc(fill, bus.sample_valid);
      fresh     <= sat_inc(fresh, bus.sample_valid);
      case (state)
        PRIME: begin
          if (fill == CNT_W'(N)) state <= ARMED;
        end
        ARMED: begin
          if (issue_go) begin
            state         <= ISSUE;
            bus.new_t     <= 1'b1;
            bus.x_flat    <= flat_nxt;
            bus.frame_cnt <= bus.frame_cnt + 16'd1;
            fresh         <= '0;
          end else if (bus.sample_valid && (fresh == CNT_W'(N))) begin
            bus.overrun <= 1'b1;
          end
        end
        ISSUE: begin
          busy_cnt <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.sample_valid && (fresh == CNT_W'(N))) bus.overrun <= 1'b1;
          // A falling fft_done proves the FFT took the frame; the timeout
          // covers a done pulse too short to be seen.
          if (!bus.fft_done || (busy_cnt == BT_W'(BUSY_TIMEOUT - 1))) begin
            state <= ARMED;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
        end
        default: state <= PRIME;
      endcase
    end
  end
endmodule

// File: tb/tb_audio_frame_buffer.sv
// Directed bench for audio_frame_buffer: priming, sign handling, FFT
// handshake, back-pressure overrun, timeout pacing and mid-run reset.
module tb_audio_frame_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  int   issues   = 0;
  int   b2b      = 0;
  int   cyc      = 0;
  int   last_cyc = -1;
  int   min_gap  = 1000;
  logic prev_nt  = 1'b0;

  audio_frame_buffer_if #(.N(32), .SAMPLE_W(18)) bus();

  audio_frame_buffer #(.N(32), .SAMPLE_W(18), .HOP(16), .BUSY_TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Count frame strobes, back-to-back strobes and the tightest spacing.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    prev_nt <= bus.new_t;
    if (bus.new_t) begin
      issues <= issues + 1;
      if (prev_nt) b2b <= b2b + 1;
      if (last_cyc >= 0 && (cyc - last_cyc) < min_gap) min_gap <= cyc - last_cyc;
      last_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] xk(input int k);
    return {14'b0, bus.x_flat[18*k +: 18]};
  endfunction

  task automatic send(input int v);
    bus.sample_in    = 18'(v);
    bus.sample_valid = 1'b1;
    @(negedge clk);
    bus.sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_issue(input string tag, input int budget);
    int start;
    int n;
    start = issues;
    n = 0;
    while (issues == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(issues != start), 32'd1);
  endtask

  initial begin
    int start;
    int n;
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int start;
    int n;
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.fft_done     = 1'b0;
    idle(2);
    check("rst_x_flat", 32'(|bus.x_flat), 32'd0);
    check("rst_new_t", 32'(bus.new_t), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    rst = 1'b1;
    idle(1);

    // Priming: 31 samples give nothing, the 32nd releases the first frame.
    bus.fft_done = 1'b1;
    for (int i = 1; i <= 31; i++) send(i);
    idle(3);
    check("prime_no_issue", 32'(issues), 32'd0);
    send(32);
    wait_issue("prime_issue", 10);
    check("prime_x0", xk(0), 32'd1);
    check("prime_x31", xk(31), 32'd32);
    check("prime_frame_cnt", 32'(bus.frame_cnt), 32'd1);

    // Handshake: done high 3 cycles, low while 16 fresh samples arrive.
    idle(3);
    bus.fft_done = 1'b0;
    idle(5);
    for (int i = 33; i <= 48; i++) send(i);
    idle(2);
    check("hs_no_issue_busy", 32'(issues), 32'd1);
    bus.fft_done = 1'b1;
    wait_issue("hs_issue", 10);
    check("hs_x0", xk(0), 32'd17);
    check("hs_x31", xk(31), 32'd48);
    check("hs_frame_cnt", 32'(bus.frame_cnt), 32'd2);
    idle(12);
    check("hs_single_issue", 32'(issues), 32'd2);
    check("hs_overrun_clear", 32'(bus.overrun), 32'd0);

    // Back-pressure: 40 samples while the FFT stays busy.
    bus.fft_done = 1'b0;
    for (int i = 100; i <= 139; i++) send(i);
    idle(2);
    check("bp_no_issue", 32'(issues), 32'd2);
    check("bp_overrun", 32'(bus.overrun), 32'd1);
    bus.fft_done = 1'b1;
    wait_issue("bp_issue", 10);
    check("bp_x0", xk(0), 32'd108);
    check("bp_x31", xk(31), 32'd139);
    check("bp_overrun_sticky", 32'(bus.overrun), 32'd1);
    check("bp_frame_cnt", 32'(bus.frame_cnt), 32'd3);

    // Sign extremes as the two newest samples.
    bus.fft_done = 1'b0;
    for (int i = 200; i <= 213; i++) send(i);
    send(-131072);
    send(131071);
    bus.fft_done = 1'b1;
    wait_issue("sign_issue", 12);
    check("sign_x0", xk(0), 32'd124);
    check("sign_x29", xk(29), 32'd213);
    check("sign_x30", xk(30), 32'h20000);
    check("sign_x31", xk(31), 32'h1FFFF);
    check("sign_frame_cnt", 32'(bus.frame_cnt), 32'd4);

    // Timeout pacing: done stuck high, continuous stream.
    idle(10);
    last_cyc = -1;
    min_gap  = 1000;
    start    = issues;
    for (int i = 0; i < 120; i++) send(300 + i);
    check("to_issue_count", 32'((issues - start) >= 6), 32'd1);
    check("to_min_gap", 32'(min_gap >= 16), 32'd1);
    check("to_no_b2b", 32'(b2b), 32'd0);

    // Mid-run reset while in WAIT_BUSY.
    start = issues;
    n = 0;
    while (issues == start && n < 40) begin
      send(500 + n);
      n++;
    end
    check("mr_reach_issue", 32'(issues != start), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mr_x_flat", 32'(|bus.x_flat), 32'd0);
    check("mr_new_t", 32'(bus.new_t), 32'd0);
    check("mr_overrun", 32'(bus.overrun), 32'd0);
    check("mr_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    start = issues;
    for (int i = 1001; i <= 1031; i++) send(i);
    idle(4);
    check("mr_reprime_no_issue", 32'(issues - start), 32'd0);
    send(1032);
    wait_issue("mr_issue", 10);
    check("mr_x0", xk(0), 32'd1001);
    check("mr_x31", xk(31), 32'd1032);
    check("mr_frame_cnt_1", 32'(bus.frame_cnt), 32'd1);
    check("mr_no_b2b", 32'(b2b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
